encoder_4x2_stream: RTL
=======================

Name: encoder_4x2_stream

Overview:
- Inverse of the 2x4 decoder: takes a 4-bit line vector D[0:3] plus enable E, and produces the 2-bit code {A,B}, a valid-code flag V and a multi-hot flag.
- Encoding is registered and buffered in a small FIFO with valid/ready handshakes on both sides.
- Sits between line-level sources, such as decoder outputs looped back or keypad lines, and code consumers.
- Lets the design round-trip the decoder, so a decode-then-encode returns the original {A,B}.

Parameters:
- DEPTH, 2, number of encoded entries buffered; legal values are 1..8.
- CNT_W, 8, width of the error counter (used only under the optional feature).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- D, in, [0:3], input lines; D[i] corresponds to code i = {A,B}, with D[0] ↔ 00 and D[3] ↔ 11.
- E, in, 1, line enable; E=0 means the word is encoded as "no line active".
- in_valid, in, 1, D/E word present.
- in_ready, out, 1, block can accept a word this cycle.
- A, out, 1, code MSB.
- B, out, 1, code LSB.
- V, out, 1, at least one enabled line was active.
- multi, out, 1, more than one enabled line was active.
- out_valid, out, 1, A/B/V/multi hold a valid entry.
- out_ready, in, 1, consumer takes the entry.
- err_cnt, out, CNT_W, count of multi-hot words accepted; reads 0 when the feature is off.

Behaviour:
- Reset: synchronous, active-high. The next rising edge with rst=1 applies reset.
  - Clears the FIFO (count=0, read and write pointers = 0).
  - Forces out_valid=0, A=0, B=0, V=0, multi=0, err_cnt=0.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards all buffered entries, with no partial output.
- Encode (combinational, before the FIFO write):
  - Effective lines L = E ? D : 4'b0000.
  - Priority: the highest index wins, i.e. D[3] > D[2] > D[1] > D[0].
  - Code = index of the highest set bit of L.
  - V = |L.
  - multi = popcount(L) > 1.
  - L = 0 gives A=0, B=0, V=0, multi=0.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !rst && (count < DEPTH), derived from registered state only. It has no combinational path from out_ready.
  - Pop occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - A/B/V/multi show the head entry and are stable while out_valid && !out_ready.
  - Latency: a word accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty. There is no combinational input-to-output path.
- Occupancy states:
  - EMPTY (count=0): push only; goes to PARTIAL, or to FULL if DEPTH=1.
  - PARTIAL: push only → count+1; pop only → count−1; push and pop together → count unchanged, head advances and the tail is written.
  - FULL (count=DEPTH): in_ready=0; pop → PARTIAL, or EMPTY if DEPTH=1.
- Pointer wrap: pointers wrap modulo DEPTH. For non-power-of-2 DEPTH use an explicit compare-to-(DEPTH−1) reset; do not rely on truncation.
- Boundary conditions:
  - Pop and in_valid while FULL: the pop happens and the push is refused that cycle.
  - in_valid while E=0: accepted as an all-zero code (V=0). It is not dropped.
  - A vector with X/Z values is not a legal stimulus.

Optional Feature:
- Macro ENC_ERR_COUNT_EN.
- Defined:
  - err_cnt increments by 1 on every accepted word with multi=1.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - It is cleared only by rst.
- Undefined:
  - No counter logic is built.
  - err_cnt is tied to 0.
  - The multi flag is still produced.

Decomposition:
- Package encoder_pkg:
  - CODE_W=2, LINES=4, DEPTH_DEFAULT=2.
  - Typedef enc_entry_t = {A, B, V, multi} (4 bits).
  - Function prio_encode(lines) → enc_entry_t.
- Sub-module enc_fifo: a generic synchronous FIFO of enc_entry_t, parameterised by DEPTH, exposing push/pop/count/full/empty. The top level holds the encode logic, the handshake glue and the optional counter.

Test Plan:
- Reset, then one-hot sweep with E=1 and out_ready=1:
  - D=1000 → {A,B}=00, V=1, multi=0.
  - D=0100 → 01.
  - D=0010 → 10.
  - D=0001 → 11.
  - Each appears one cycle after the accept.
- Enable off, E=0, D=0001 → A=0, B=0, V=0, multi=0, out_valid=1.
- Priority/multi-hot, E=1, D=1011 → {A,B}=11, V=1, multi=1; with ENC_ERR_COUNT_EN, err_cnt goes 0→1.
- Backpressure with DEPTH=2 and out_ready=0:
  - Push D=1000 then D=0010.
  - in_ready drops to 0 after the second accept, and a third word is refused.
  - Raising out_ready drains 00 then 10 in order.
- Simultaneous push and pop while PARTIAL: count stays 1 and output order is preserved across wrap for 10 consecutive words.
- Reset mid-operation:
  - With 2 entries buffered, assert rst for 1 cycle.
  - Next cycle: out_valid=0, err_cnt=0, in_ready=1 after rst deasserts.
- Round-trip: the decoder output fed into this block reproduces the {A,B} input for all 4 codes.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and the priority-encode function for the 4-to-2 line encoder stream.
package encoder_pkg;

  localparam int CODE_W        = 2;
  localparam int LINES         = 4;
  localparam int DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic a;
    logic b;
    logic v;
    logic multi;
  } enc_entry_t;

  // Highest set index wins; later iterations overwrite the code.
  function automatic enc_entry_t prio_encode(input logic [0:LINES-1] lines);
    enc_entry_t e;
    int         cnt;
    e   = '0;
    cnt = 0;
    for (int i = 0; i < LINES; i++) begin
      if (lines[i]) begin
        {e.a, e.b} = CODE_W'(i);
        cnt++;
      end
    end
    e.v     = (cnt != 0);
    e.multi = (cnt > 1);
    return e;
  endfunction

endpackage

// File: rtl/encoder_4x2_stream_fifo.sv
// Generic synchronous FIFO of encoded entries.
// Pointers wrap by explicit compare, so any DEPTH from 1 to 8 works.
module enc_fifo
  import encoder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  enc_entry_t                   wr_data,
  output enc_entry_t                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_B = $clog2(DEPTH + 1);

  enc_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_B-1:0]       count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_B'(1);
        2'b01:   count_reg <= count_reg - CNT_B'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_reg;
  assign full    = (count_reg == CNT_B'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/encoder_4x2_stream.sv
// 4-to-2 priority encoder with a valid/ready FIFO on the output side.
// Optional multi-hot error counter is built only when ENC_ERR_COUNT_EN is defined.
module encoder_4x2_stream
  import encoder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:3]       D,
  input  logic             E,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             A,
  output logic             B,
  output logic             V,
  output logic             multi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CNT_B = $clog2(DEPTH + 1);

  enc_entry_t       enc;
  enc_entry_t       head;
  enc_entry_t       rd_data;
  logic [CNT_B-1:0] count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;

  assign enc      = prio_encode(E ? D : 4'b0000);
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop),
    .wr_data (enc),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Storage is not cleared on reset, so mask stale contents when empty.
  assign head  = empty ? '0 : rd_data;
  assign A     = head.a;
  assign B     = head.b;
  assign V     = head.v;
  assign multi = head.multi;

`ifdef ENC_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (accept && enc.multi && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = '0;
`endif

endmodule
